// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial frame transmitter: state encoding,
// line levels and a width helper used for the internal counters.
package serial_tx_pkg;

  // Transmitter states; the frame walks IDLE -> START -> DATA -> STOP -> IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Serial line levels: the line rests high and a frame opens with a low bit.
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit period timer: counts CLKS_PER_BIT cycles while run is high and pulses
// bit_end on the last cycle of every bit period. Idle (run low) holds it at 0
// so the first period after run rises is always full length.
module serial_tx_bit_timer
  import serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic R,
  input  logic run,
  output logic bit_end
);

  localparam int CW = min1_clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_end = run && (cnt == LAST_CNT);

  // Cycle counter: 0..CLKS_PER_BIT-1, wraps at each bit boundary, cleared when idle.
  always_ff @(posedge clk) begin
    if (R) begin
      cnt <= '0;
    end else if (!run || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter. One word per load/ready
// handshake is sent as: start bit (low), DATA_W data bits LSB first,
// stop bit (high); each bit is held for CLKS_PER_BIT cycles.
//
// Handshake: a word is accepted on a rising edge where load && ready.
// ready is high only in IDLE; load at any other time is ignored and din is
// not looked at until the next acceptance.
//
// txd is registered and computed from the next state, so it has no
// combinational path from any input and changes exactly on state edges.
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              R,
  input  logic [DATA_W-1:0] din,
  input  logic              load,
  output logic              ready,
  output logic              txd,
  output logic              busy,
  output logic              done,
  output tx_state_e         dbg_state
);

  localparam int IW = min1_clog2(DATA_W);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  tx_state_e         state, state_d;
  logic [DATA_W-1:0] shreg, shreg_d;
  logic [IW-1:0]     idx, idx_d;
  logic              txd_q, txd_d;
  logic              bit_end;
  logic              run;

  assign run = (state != ST_IDLE);

  serial_tx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .R       (R),
    .run     (run),
    .bit_end (bit_end)
  );

  // Next-state, shift register and next line level.
  always_comb begin
    state_d = state;
    shreg_d = shreg;
    idx_d   = idx;
    txd_d   = LINE_IDLE;
    case (state)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_START;
          shreg_d = din;
          idx_d   = '0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_d = shreg >> 1;
          if (idx == LAST_IDX) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    case (state_d)
      ST_START: txd_d = LINE_START;
      ST_DATA:  txd_d = shreg_d[0];
      default:  txd_d = LINE_IDLE;
    endcase
  end

  // State, shift register, bit index and line register; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (R) begin
      state <= ST_IDLE;
      shreg <= '0;
      idx   <= '0;
      txd_q <= LINE_IDLE;
    end else begin
      state <= state_d;
      shreg <= shreg_d;
      idx   <= idx_d;
      txd_q <= txd_d;
    end
  end

  assign txd       = txd_q;
  assign ready     = (state == ST_IDLE);
  assign busy      = !ready;
  assign done      = (state == ST_STOP) && bit_end;
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: two instances (8 bits x 4 clks, 4 bits x 1 clk) driven
// by directed vectors. A frame-level model predicts every output each cycle
// from the frame offset; literal slot patterns pin the model.
module tb_serial_tx;
  import serial_tx_pkg::*;

  localparam int A_W = 8;
  localparam int A_C = 4;
  localparam int A_N = (A_W + 2) * A_C;
  localparam int B_W = 4;
  localparam int B_C = 1;
  localparam int B_N = (B_W + 2) * B_C;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic R;
  always #5 clk = ~clk;

  logic [A_W-1:0] a_din;
  logic           a_load, a_ready, a_txd, a_busy, a_done;
  tx_state_e      a_dbg;
  logic [B_W-1:0] b_din;
  logic           b_load, b_ready, b_txd, b_busy, b_done;
  tx_state_e      b_dbg;

  serial_tx #(.DATA_W(A_W), .CLKS_PER_BIT(A_C)) dut_a (
    .clk(clk), .R(R), .din(a_din), .load(a_load), .ready(a_ready),
    .txd(a_txd), .busy(a_busy), .done(a_done), .dbg_state(a_dbg)
  );

  serial_tx #(.DATA_W(B_W), .CLKS_PER_BIT(B_C)) dut_b (
    .clk(clk), .R(R), .din(b_din), .load(b_load), .ready(b_ready),
    .txd(b_txd), .busy(b_busy), .done(b_done), .dbg_state(b_dbg)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame model ----------------
  // t = offset of the current cycle inside a frame (1..N), 0 when idle.
  int             a_t = 0;
  int             b_t = 0;
  logic [7:0]     a_word;
  logic [7:0]     b_word;

  function automatic logic exp_txd(input int t, input int cpb, input int w, input logic [7:0] word);
    int slot;
    if (t == 0) return 1'b1;
    slot = (t - 1) / cpb;
    if (slot == 0) return 1'b0;
    if (slot <= w) return word[slot-1];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (R) begin
      a_t = 0;
      b_t = 0;
    end else begin
      if (a_t == 0) begin
        if (a_load) begin a_t = 1; a_word = a_din; end
      end else if (a_t == A_N) a_t = 0;
      else a_t++;
      if (b_t == 0) begin
        if (b_load) begin b_t = 1; b_word = {4'h0, b_din}; end
      end else if (b_t == B_N) b_t = 0;
      else b_t++;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("a_txd",   {31'd0, a_txd},   {31'd0, exp_txd(a_t, A_C, A_W, a_word)});
      check("a_ready", {31'd0, a_ready}, {31'd0, a_t == 0});
      check("a_busy",  {31'd0, a_busy},  {31'd0, a_t != 0});
      check("a_done",  {31'd0, a_done},  {31'd0, a_t == A_N});
      check("b_txd",   {31'd0, b_txd},   {31'd0, exp_txd(b_t, B_C, B_W, b_word)});
      check("b_ready", {31'd0, b_ready}, {31'd0, b_t == 0});
      check("b_busy",  {31'd0, b_busy},  {31'd0, b_t != 0});
      check("b_done",  {31'd0, b_done},  {31'd0, b_t == B_N});
    end
  end

  // ---------------- driver tasks ----------------
  logic cap_txd  [0:63];
  logic cap_done [0:63];
  logic cap_rdy  [0:63];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Records n cycles of one instance's outputs (cycle 1 = first after load edge);
  // optionally pulses a load of 0xFF into instance A at cycle inj.
  task automatic capture(input int sel, input int n, input int inj);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      cap_txd[c]  = sel ? b_txd  : a_txd;
      cap_done[c] = sel ? b_done : a_done;
      cap_rdy[c]  = sel ? b_ready : a_ready;
      if (c == inj) begin a_load = 1'b1; a_din = 8'hFF; end
      if (c == inj + 1) a_load = 1'b0;
    end
  endtask

  // Checks captured instance-A frame against a literal 10-slot pattern.
  task automatic check_a_slots(input string name, input logic [9:0] slots);
    int first_done;
    int done_cnt;
    first_done = 0;
    done_cnt   = 0;
    for (int c = 1; c <= A_N; c++) begin
      check(name, {31'd0, cap_txd[c]}, {31'd0, slots[(c-1)/A_C]});
      if (cap_done[c]) begin
        done_cnt++;
        if (first_done == 0) first_done = c;
      end
    end
    check({name, "_done_cycle"}, first_done, A_N);
    check({name, "_done_count"}, done_cnt, 1);
  endtask

  task automatic load_a(input logic [7:0] w);
    a_din  = w;
    a_load = 1'b1;
    step();
    a_load = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int d;
    int s;
    int busy_cnt;
    logic [9:0] slots;
    logic [5:0] bslots;

    R = 1'b1; a_load = 1'b1; b_load = 1'b1; a_din = 8'hA5; b_din = 4'hF;

    // Reset with load held high: stays idle, no frame.
    step();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_txd", {31'd0, a_txd}, 32'd1);
    check("rst_ready", {31'd0, a_ready}, 32'd1);
    check("rst_busy", {31'd0, a_busy}, 32'd0);
    check("rst_done", {31'd0, a_done}, 32'd0);
    check("rst_state", {30'd0, a_dbg}, {30'd0, ST_IDLE});
    check("rst_b_state", {30'd0, b_dbg}, {30'd0, ST_IDLE});
    step();
    R = 1'b0; a_load = 1'b0; b_load = 1'b0;
    @(negedge clk);
    check("rst2_ready", {31'd0, a_ready}, 32'd1);
    check("rst2_txd", {31'd0, b_txd}, 32'd1);
    step();
    @(negedge clk);
    check("post_rst_idle", {31'd0, a_busy}, 32'd0);

    // Single 0xA5 frame: slots 0,1,0,1,0,0,1,0,1,1.
    step();
    load_a(8'hA5);
    capture(0, A_N + 1, -5);
    slots = 10'b1101001010;
    check_a_slots("a5_slot", slots);
    check("a5_ready_after", {31'd0, cap_rdy[A_N+1]}, 32'd1);
    check("a5_ready_last", {31'd0, cap_rdy[A_N]}, 32'd0);

    // Load of 0xFF at cycle k+10 is ignored; no second frame.
    step();
    load_a(8'hA5);
    capture(0, A_N, 10);
    check_a_slots("ign_slot", slots);
    busy_cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (a_busy) busy_cnt++;
    end
    check("ign_no_second", busy_cnt, 0);

    // Back-to-back with load held high: 0x00 then 0xFF.
    step();
    a_din = 8'h00; a_load = 1'b1;
    step();
    a_din = 8'hFF;
    d = 0; s = 0;
    for (int c = 1; c <= 60 && s == 0; c++) begin
      @(negedge clk);
      if (a_done && d == 0) d = c;
      else if (d != 0 && a_txd == 1'b0) s = c;
    end
    a_load = 1'b0;
    check("b2b_done1", d, A_N);
    check("b2b_start2", s, A_N + 2);
    capture(0, A_N - 1, -5);
    for (int c = 1; c <= A_N - 1; c++)
      check("b2b_ff_txd", {31'd0, cap_txd[c]}, {31'd0, (c + 1) > A_C});
    check("b2b_done2", {31'd0, cap_done[A_N-1]}, 32'd1);

    // Reset at cycle k+20 aborts; then a clean 0x3C frame.
    step();
    step();
    load_a(8'h5A);
    repeat (19) step();
    R = 1'b1;
    step();
    R = 1'b0;
    @(negedge clk);
    check("midrst_txd", {31'd0, a_txd}, 32'd1);
    check("midrst_ready", {31'd0, a_ready}, 32'd1);
    step();
    load_a(8'h3C);
    capture(0, A_N, -5);
    slots = 10'b1001111000;
    check_a_slots("3c_slot", slots);

    // One clock per bit, 4 data bits, 0x9: 0,1,0,0,1,1 with done at k+6.
    step();
    b_din = 4'h9; b_load = 1'b1;
    step();
    b_load = 1'b0;
    capture(1, B_N + 1, -5);
    bslots = 6'b110010;
    for (int c = 1; c <= B_N; c++) begin
      check("b9_txd", {31'd0, cap_txd[c]}, {31'd0, bslots[c-1]});
      check("b9_done", {31'd0, cap_done[c]}, {31'd0, c == B_N});
    end
    check("b9_ready_after", {31'd0, cap_rdy[B_N+1]}, 32'd1);

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
Parallel-in, serial-out frame transmitter. It produces the serial bit stream that our flip-flop and shift-register receive chains sample on clk. It accepts one DATA_W-bit word per load/ready handshake and drives it onto txd as a framed serial sequence: start bit, data bits LSB first, then stop bit. Each bit is held for CLKS_PER_BIT clock cycles.

Parameters:
DATA_W, 8, data bits per frame (>=1)
CLKS_PER_BIT, 4, clk cycles each serial bit is held (>=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
R  input  1  reset, synchronous, active-high
din  input  DATA_W  word to transmit, sampled when load&&ready
load  input  1  request to start a frame
ready  output  1  high only when idle and able to accept load
txd  output  1  serial line, idle-high, registered
busy  output  1  high while a frame is in progress (START/DATA/STOP)
done  output  1  one-cycle pulse in the final cycle of the stop bit

Behaviour:
- Reset: R sampled high at a rising edge forces the following outputs and state:
  - state=IDLE, txd=1, ready=1, busy=0, done=0.
  - Shift register, bit counter and cycle counter all cleared.
  - R wins over load in the same cycle.
  - Reset mid-frame aborts the frame; txd returns to 1 after that edge.
- States: IDLE, START, DATA, STOP. Encoding is one-hot or binary; it is internal.
- Derived outputs: ready = (state==IDLE); busy = !ready.
- IDLE: txd=1. If load=1 at edge k:
  - din is captured into the shift register.
  - state->START; txd=0 from cycle k+1 (1-cycle latency).
- START: txd=0 for CLKS_PER_BIT cycles, then ->DATA with bit index 0.
- DATA: txd = shift_reg[0]. Each bit is held CLKS_PER_BIT cycles, then the register shifts right and the index increments. After bit DATA_W-1 completes, ->STOP.
- STOP: txd=1 for CLKS_PER_BIT cycles. done=1 in the last STOP cycle, which is cycle k+(DATA_W+2)*CLKS_PER_BIT. Then ->IDLE.
- Frame timing:
  - Total frame: (DATA_W+2)*CLKS_PER_BIT cycles.
  - Data bit i occupies cycles k+1+(i+1)*CLKS_PER_BIT through k+(i+2)*CLKS_PER_BIT.
- Back-to-back frames: ready rises the cycle after done. Minimum spacing is one IDLE cycle, so the next start bit begins 2 cycles after done.
- load while busy: ignored. din changes during a frame do not affect the frame in flight.
- Cycle counter: width clog2(CLKS_PER_BIT), minimum 1 bit. Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- CLKS_PER_BIT=1: every bit lasts exactly 1 cycle, and done coincides with the single STOP cycle.
- Bit index: width clog2(DATA_W), minimum 1 bit. Never exceeds DATA_W-1.
- No combinational path from any input to txd.

Decomposition:
- Shared package holds:
  - State encoding constants: ST_IDLE, ST_START, ST_DATA, ST_STOP.
  - Line level constants: LINE_IDLE=1, LINE_START=0.
- One sub-module: bit_timer, parameterised by CLKS_PER_BIT.
  - Inputs: clk, R, run.
  - Output: bit_end, a pulse on the last cycle of each bit period.
  - serial_tx instantiates it once.

Test Plan:
- Reset: R=1 for 2 cycles with load=1 -> txd=1, ready=1, busy=0, done=0 throughout, and no frame starts.
- Single frame, DATA_W=8, CLKS_PER_BIT=4, din=0xA5, load at edge k:
  - txd per 4-cycle slot is 0,1,0,1,0,0,1,0,1,1.
  - done=1 only at cycle k+40; ready=1 again at k+41.
- Busy ignore: load=1 with din=0xFF at cycle k+10 of a 0xA5 frame -> serial output still carries 0xA5, and no second frame follows.
- Back-to-back: load held high continuously with din=0x00 then 0xFF -> second start bit falls exactly 2 cycles after the first done, and each frame decodes correctly.
- Reset mid-frame: R=1 at cycle k+20 -> txd=1 and ready=1 from the next edge. A new load of 0x3C afterwards transmits a clean full frame.
- CLKS_PER_BIT=1, DATA_W=4, din=0x9 -> txd sequence 0,1,0,0,1,1 over cycles k+1..k+6, with done at k+6.
